dm_access_ctrl: RTL and testbench

Sequencer for the data-memory stage of the 5-stage pipeline. It sits between the EX/DM pipeline register outputs and a multi-cycle data memory with a req/ack handshake. It issues each load/store exactly once and holds a pipeline-wide stall until the access completes. It also delivers captured load data toward DM/WB and traps illegal or hung accesses.

---
 rtl/dm_ctrl_pkg.sv | 12 +
 rtl/dm_timeout_ctr.sv | 18 +
 rtl/dm_access_ctrl.sv | 68 ++++++
 tb/tb_dm_access_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: shared state encoding, default timeout and trap-cause codes for the DM sequencer
package dm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_e;
  localparam int DEFAULT_TIMEOUT = 15;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  function automatic logic [1:0] access_cause(input logic rd, input logic wr, input logic [1:0] lsb);
    return (rd && wr) ? ERR_RW : (lsb != 2'b00) ? ERR_MISALIGN : ERR_NONE;
  endfunction
endpackage

// File: rtl/dm_timeout_ctr.sv
// dm_timeout_ctr: clear/enable wait counter; exp_o flags the MAX-th enabled cycle
module dm_timeout_ctr #(
  parameter int MAX = 15,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (reset || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  // counter would reach MAX at the end of this enabled cycle
  assign exp_o = en_i && (cnt_q == W'(MAX - 1));
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: issues one DM access per load/store, stalls the pipe until ack, traps bad or hung accesses
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] Mem_address,
  input  logic [DATA_W-1:0] Write_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              load_valid,
  output logic              err_out
);
  state_e state_q, state_d;
  logic rd_q, expired, access, accept;
  logic [1:0] cause;
  assign access = mem_read_in || mem_write_in;
  dm_timeout_ctr #(.MAX(TIMEOUT)) u_ctr (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q != WAIT),
    .en_i(state_q == WAIT),
    .exp_o(expired)
  );
  always_comb begin
    cause = (state_q == IDLE && access) ? access_cause(mem_read_in, mem_write_in, Mem_address[1:0]) :
            (expired && !mem_ack) ? ERR_TIMEOUT : ERR_NONE;
    accept = state_q == IDLE && access && cause == ERR_NONE;
    state_d = (cause != ERR_NONE) ? ERR :
              accept ? WAIT :
              (state_q == WAIT && mem_ack) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      load_data_out <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q <= mem_read_in;
        mem_we <= mem_write_in;
        mem_addr <= Mem_address;
        mem_wdata <= Write_data_in;
      end
      if (state_q == WAIT && mem_ack && rd_q) load_data_out <= mem_rdata;
    end
  assign mem_req = state_q == WAIT;
  assign stall_out = (state_q == IDLE) ? access : (state_q != DONE);
  assign load_valid = state_q == DONE && rd_q;
  assign err_out = state_q == ERR;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed cycle-by-cycle checks of the DM access sequencer (TIMEOUT=4)
module tb_dm_access_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_read_in = 1'b0, mem_write_in = 1'b0, mem_ack = 1'b0;
  logic [31:0] Mem_address = '0, Write_data_in = '0, mem_rdata = '0;
  logic mem_req, mem_we, stall_out, load_valid, err_out;
  logic [31:0] mem_addr, mem_wdata, load_data_out;
  int n_cmp = 0, n_bad = 0;
  dm_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .Mem_address(Mem_address), .Write_data_in(Write_data_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall_out(stall_out), .load_data_out(load_data_out),
    .load_valid(load_valid), .err_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mem_read_in = rd;
    mem_write_in = wr;
    Mem_address = a;
    Write_data_in = d;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ldata", load_data_out, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_err", err_out, 0);
    chk("rst_stall", stall_out, 0);
    // load 0x40, ack in cycle 3
    drive(1, 0, 32'h40, 0);
    settle();
    chk("ld_c0_stall", stall_out, 1);
    chk("ld_c0_req", mem_req, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; settle(); end
      chk($sformatf("ld_c%0d_req", c), mem_req, 1);
      chk($sformatf("ld_c%0d_stall", c), stall_out, 1);
    end
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_we", mem_we, 0);
    tick();
    mem_ack = 0;
    chk("ld_c4_req", mem_req, 0);
    chk("ld_c4_stall", stall_out, 0);
    chk("ld_c4_lv", load_valid, 1);
    chk("ld_c4_data", load_data_out, 32'hDEADBEEF);
    drive(0, 0, 0, 0);
    tick();
    chk("ld_c5_lv", load_valid, 0);
    chk("ld_c5_hold", load_data_out, 32'hDEADBEEF);
    // store 0x10, ack in cycle 1
    drive(0, 1, 32'h10, 32'h12345678);
    settle();
    chk("st_c0_stall", stall_out, 1);
    chk("st_c0_lv", load_valid, 0);
    tick();
    mem_ack = 1;
    mem_rdata = 32'hBAD0BAD0;
    settle();
    chk("st_c1_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h10);
    chk("st_wdata", mem_wdata, 32'h12345678);
    chk("st_c1_stall", stall_out, 1);
    tick();
    mem_ack = 0;
    chk("st_c2_stall", stall_out, 0);
    chk("st_c2_req", mem_req, 0);
    chk("st_c2_lv", load_valid, 0);
    chk("st_keep_ldata", load_data_out, 32'hDEADBEEF);
    drive(0, 0, 0, 0);
    tick();
    // stray ack in IDLE
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_lv", load_valid, 0);
    chk("idle_ack_stall", stall_out, 0);
    // two back-to-back loads, ack latency 1
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 32'h80 + 32'(4 * k), 0);
      settle();
      chk($sformatf("b2b%0d_s0", k), stall_out, 1);
      tick();
      mem_ack = 1;
      mem_rdata = k == 0 ? 32'h11111111 : 32'h22222222;
      settle();
      chk($sformatf("b2b%0d_s1", k), stall_out, 1);
      tick();
      mem_ack = 0;
      chk($sformatf("b2b%0d_s2", k), stall_out, 0);
      chk($sformatf("b2b%0d_lv", k), load_valid, 1);
      chk($sformatf("b2b%0d_data", k), load_data_out, k == 0 ? 32'h11111111 : 32'h22222222);
      tick();
    end
    drive(0, 0, 0, 0);
    settle();
    // misaligned load
    drive(1, 0, 32'h42, 0);
    settle();
    chk("mis_c0_stall", stall_out, 1);
    tick();
    drive(0, 0, 0, 0);
    settle();
    chk("mis_err", err_out, 1);
    chk("mis_stall", stall_out, 1);
    chk("mis_req", mem_req, 0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    chk("mis_hold_err", err_out, 1);
    chk("mis_hold_req", mem_req, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("mis_rst_err", err_out, 0);
    chk("mis_rst_stall", stall_out, 0);
    chk("rst_ldata_clr", load_data_out, 0);
    // read and write together
    drive(1, 1, 32'h0, 0);
    tick();
    drive(0, 0, 0, 0);
    settle();
    chk("rw_err", err_out, 1);
    chk("rw_req", mem_req, 0);
    reset = 1;
    tick();
    reset = 0;
    // reset during WAIT cycle 2
    drive(1, 0, 32'h20, 0);
    tick();
    tick();
    chk("rw2_req", mem_req, 1);
    drive(0, 0, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("wrst_req", mem_req, 0);
    chk("wrst_err", err_out, 0);
    chk("wrst_stall", stall_out, 0);
    chk("wrst_lv", load_valid, 0);
    // timeout: full 4 WAIT cycles after reset proves the counter restarted
    drive(1, 0, 32'h30, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_c%0d_req", c), mem_req, 1);
      chk($sformatf("to_c%0d_err", c), err_out, 0);
    end
    tick();
    drive(0, 0, 0, 0);
    chk("to_err", err_out, 1);
    chk("to_req", mem_req, 0);
    chk("to_stall", stall_out, 1);
    mem_ack = 1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    chk("to_late_ack_err", err_out, 1);
    chk("to_late_ack_lv", load_valid, 0);
    chk("to_late_ack_data", load_data_out, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("end_err", err_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
